pingpong_ctrl: RTL and testbench

PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

---
 rtl/pingpong_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pingpong_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ctrl.sv
// Two-player LED ping-pong: one-hot ball on 8 LEDs, per-player scoring,
// serve/rally/game-over control driven by active-low debounced key pulses.
module pingpong_ctrl #(
    parameter int unsigned STEP_CYCLES = 25_000_000,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1_effPulse,
    input  logic       key2_effPulse,
    output logic [7:0] led_pos,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(STEP_CYCLES - 1);
    localparam logic [3:0]       WIN_4    = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_SERVE1,
        S_SERVE2,
        S_MOVE_R,
        S_MOVE_L,
        S_OVER
    } state_t;

    state_t           state, state_n;
    logic [2:0]       pos, pos_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       score1_n, score2_n;
    logic             winner_n;
    logic             k1_prev, k2_prev;
    logic             k1_ev, k2_ev;
    logic             step_done;
    logic             p1_pt, p2_pt;
    logic [7:0]       led_n;
    logic             game_over_n;

    // Falling edge on an active-low key: high last cycle, low now.
    assign k1_ev     = k1_prev & ~key1_effPulse;
    assign k2_ev     = k2_prev & ~key2_effPulse;
    assign step_done = (cnt == STEP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SERVE1;
            pos       <= 3'd0;
            cnt       <= '0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= 1'b0;
            k1_prev   <= 1'b1;
            k2_prev   <= 1'b1;
            led_pos   <= 8'h01;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            cnt       <= cnt_n;
            score1    <= score1_n;
            score2    <= score2_n;
            winner    <= winner_n;
            k1_prev   <= key1_effPulse;
            k2_prev   <= key2_effPulse;
            led_pos   <= led_n;
            game_over <= game_over_n;
        end
    end

    // Key events outrank a coinciding step and are judged on the pre-step pos.
    always_comb begin
        state_n  = state;
        pos_n    = pos;
        cnt_n    = cnt;
        score1_n = score1;
        score2_n = score2;
        winner_n = winner;
        p1_pt    = 1'b0;
        p2_pt    = 1'b0;
        case (state)
            S_SERVE1: begin
                if (k1_ev) begin
                    state_n = S_MOVE_R;
                    cnt_n   = '0;
                end
            end
            S_SERVE2: begin
                if (k2_ev) begin
                    state_n = S_MOVE_L;
                    cnt_n   = '0;
                end
            end
            S_MOVE_R: begin
                if (k2_ev) begin
                    if (pos == 3'd7) begin
                        state_n = S_MOVE_L;
                        cnt_n   = '0;
                    end else begin
                        p1_pt = 1'b1;
                    end
                end else if (step_done) begin
                    cnt_n = '0;
                    if (pos == 3'd7) p1_pt = 1'b1;
                    else             pos_n = pos + 3'd1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_MOVE_L: begin
                if (k1_ev) begin
                    if (pos == 3'd0) begin
                        state_n = S_MOVE_R;
                        cnt_n   = '0;
                    end else begin
                        p2_pt = 1'b1;
                    end
                end else if (step_done) begin
                    cnt_n = '0;
                    if (pos == 3'd0) p2_pt = 1'b1;
                    else             pos_n = pos - 3'd1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_OVER: begin
                if (k1_ev || k2_ev) begin
                    state_n  = S_SERVE1;
                    pos_n    = 3'd0;
                    cnt_n    = '0;
                    score1_n = 4'd0;
                    score2_n = 4'd0;
                    winner_n = 1'b0;
                end
            end
            default: begin
                state_n = S_SERVE1;
                pos_n   = 3'd0;
                cnt_n   = '0;
            end
        endcase

        // Loser of the point serves next, unless the point ends the game.
        if (p1_pt) begin
            score1_n = score1 + 4'd1;
            cnt_n    = '0;
            if (score1_n == WIN_4) begin
                state_n  = S_OVER;
                winner_n = 1'b0;
            end else begin
                state_n = S_SERVE2;
                pos_n   = 3'd7;
            end
        end
        if (p2_pt) begin
            score2_n = score2 + 4'd1;
            cnt_n    = '0;
            if (score2_n == WIN_4) begin
                state_n  = S_OVER;
                winner_n = 1'b1;
            end else begin
                state_n = S_SERVE1;
                pos_n   = 3'd0;
            end
        end
    end

    // Registered display outputs follow the next state so they align with it.
    always_comb begin
        game_over_n = (state_n == S_OVER);
        led_n       = game_over_n ? 8'h00 : (8'h01 << pos_n);
    end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with STEP_CYCLES=4, WIN_SCORE=3.
module tb_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key1_effPulse;
    logic       key2_effPulse;
    logic [7:0] led_pos;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    int tests = 0;
    int fails = 0;

    pingpong_ctrl #(.STEP_CYCLES(4), .WIN_SCORE(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .key1_effPulse (key1_effPulse),
        .key2_effPulse (key2_effPulse),
        .led_pos       (led_pos),
        .score1        (score1),
        .score2        (score2),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse1();
        key1_effPulse = 1'b0;
        tick();
        key1_effPulse = 1'b1;
    endtask

    task automatic pulse2();
        key2_effPulse = 1'b0;
        tick();
        key2_effPulse = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_led, input logic [3:0] e_s1,
                           input logic [3:0] e_s2, input logic e_go, input logic e_win);
        chk({tag, ".led"},    led_pos,          e_led);
        chk({tag, ".score1"}, 8'(score1),       8'(e_s1));
        chk({tag, ".score2"}, 8'(score2),       8'(e_s2));
        chk({tag, ".over"},   8'(game_over),    8'(e_go));
        chk({tag, ".winner"}, 8'(winner),       8'(e_win));
    endtask

    initial begin
        rst           = 1'b1;
        key1_effPulse = 1'b1;
        key2_effPulse = 1'b1;
        tick(3);
        chk_all("reset", 8'h01, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Serve from player 1 and walk the ball to the far end.
        pulse1();
        chk("serve1", led_pos, 8'h01);
        for (int i = 1; i < 8; i++) begin
            tick(4);
            chk($sformatf("walk_r%0d", i), led_pos, 8'h01 << i);
        end
        pulse2();
        chk("hit2", led_pos, 8'h80);
        tick(4);
        chk_all("return", 8'h40, 4'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-rally, checked before the next edge.
        #3 rst = 1'b1;
        #1 chk_all("async_rst", 8'h01, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick();

        // Player 2 misses at the far end.
        pulse1();
        tick(28);
        chk("at_end", led_pos, 8'h80);
        tick(4);
        chk_all("miss2", 8'h80, 4'd1, 4'd0, 1'b0, 1'b0);

        // Wrong key ignored in SERVE2; player 1 swings at pos 7 on leftward move.
        pulse1();
        chk_all("ign_k1", 8'h80, 4'd1, 4'd0, 1'b0, 1'b0);
        pulse2();
        pulse1();
        chk_all("fault1", 8'h01, 4'd1, 4'd1, 1'b0, 1'b0);

        // Collision: key2 coincides with the step from 6 to 7.
        pulse2();
        chk_all("ign_k2", 8'h01, 4'd1, 4'd1, 1'b0, 1'b0);
        pulse1();
        tick(24);
        tick(3);
        chk("pre_coll", led_pos, 8'h40);
        pulse2();
        chk_all("collide", 8'h80, 4'd2, 4'd1, 1'b0, 1'b0);
        tick(4);
        chk("serve2_hold", led_pos, 8'h80);

        // Player 1 returns from pos 0, then player 2 swings early at pos 3.
        pulse2();
        tick(28);
        chk("at_p1", led_pos, 8'h01);
        pulse1();
        tick(12);
        chk("led08", led_pos, 8'h08);
        key2_effPulse = 1'b0;
        tick();
        chk_all("win1", 8'h00, 4'd3, 4'd1, 1'b1, 1'b0);
        tick();
        chk_all("held_over", 8'h00, 4'd3, 4'd1, 1'b1, 1'b0);
        key2_effPulse = 1'b1;
        tick(4);
        chk_all("frozen", 8'h00, 4'd3, 4'd1, 1'b1, 1'b0);

        // Restart from OVER with key2 held low for several cycles.
        key2_effPulse = 1'b0;
        tick();
        chk_all("restart", 8'h01, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        chk("restart_held", led_pos, 8'h01);
        key2_effPulse = 1'b1;
        tick();
        pulse1();
        tick(4);
        chk("after_restart", led_pos, 8'h02);

        // Player 2 wins: three player-1 faults right after a return.
        tick(24);
        pulse2();
        pulse1();
        chk_all("p2_pt1", 8'h01, 4'd0, 4'd1, 1'b0, 1'b0);
        for (int r = 2; r <= 3; r++) begin
            tick();
            pulse1();
            tick(28);
            pulse2();
            pulse1();
            chk($sformatf("p2_pt%0d", r), 8'(score2), 8'(r));
        end
        chk_all("win2", 8'h00, 4'd0, 4'd3, 1'b1, 1'b1);

        // Asynchronous reset while in OVER, then first event judged from SERVE1.
        #3 rst = 1'b1;
        #1 chk_all("rst_over", 8'h01, 4'd0, 4'd0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick();
        pulse2();
        chk("post_rst_k2", led_pos, 8'h01);
        pulse1();
        tick(4);
        chk("post_rst_serve", led_pos, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
